// File: rtl/knn_acc_core_multi_if.sv
// Handshake/bus bundle between the KNN accelerator core, its input buffer and the PE array.
// The core takes the slave view; the environment driving it takes the master view.
interface knn_acc_core_multi_if #(
  parameter int NUM_PE   = 4,
  parameter int SAMPLE_W = 32,
  parameter int ADDR_W   = 8,
  parameter int LINE_W   = 9,
  parameter int CNT_W    = 11
);
  logic                       start;
  logic                       abort;
  logic                       early_stop_en;
  logic [CNT_W-1:0]           threshold;
  logic [LINE_W-1:0]          num_lines;
  logic                       buf_rd_en;
  logic [ADDR_W-1:0]          buf_addr;
  logic [NUM_PE*SAMPLE_W-1:0] buf_rdata;
  logic [NUM_PE*SAMPLE_W-1:0] pe_sample_data;
  logic                       pe_classify_en;
  logic [NUM_PE-1:0]          pe_done;
  logic [NUM_PE-1:0]          pe_class;
  logic [CNT_W-1:0]           stress_count;
  logic                       busy;
  logic                       knn_done;
  logic                       knn_classification;
  logic                       timeout_err;

  modport slave (
    input  start, abort, early_stop_en, threshold, num_lines, buf_rdata, pe_done, pe_class,
    output buf_rd_en, buf_addr, pe_sample_data, pe_classify_en, stress_count, busy,
           knn_done, knn_classification, timeout_err
  );

  modport master (
    output start, abort, early_stop_en, threshold, num_lines, buf_rdata, pe_done, pe_class,
    input  buf_rd_en, buf_addr, pe_sample_data, pe_classify_en, stress_count, busy,
           knn_done, knn_classification, timeout_err
  );
endinterface

// File: rtl/knn_acc_core_multi.sv
// KNN accelerator core controller: streams buffer lines to NUM_PE PEs, collects per-lane votes
// into a saturating stress count and issues a thresholded decision, with watchdog and abort.
module knn_acc_core_multi #(
  parameter int NUM_PE    = 4,
  parameter int SAMPLE_W  = 32,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 1,
  parameter int LINE_W    = 9,
  parameter int CNT_W     = 11,
  parameter int TIMEOUT   = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  knn_acc_core_multi_if.slave     bus
);

  localparam int PC_W = $clog2(NUM_PE + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT     = 3'd2,
    S_CLASSIFY = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e                     state_q;
  logic [LINE_W-1:0]          line_idx_q;
  logic [CNT_W-1:0]           count_q;
  logic [NUM_PE-1:0]          done_mask_q;
  logic [WD_W-1:0]            wdog_q;
  logic                       rd_en_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [NUM_PE*SAMPLE_W-1:0] sample_q;
  logic                       classify_en_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       class_q;
  logic                       timeout_q;

  logic [NUM_PE-1:0]          new_done_d;
  logic [NUM_PE-1:0]          mask_d;
  logic [CNT_W-1:0]           count_d;
  logic                       line_full_d;
  logic [LINE_W:0]            eff_lines_d;
  logic                       last_line_d;
  logic                       early_hit_d;
  logic [WD_W-1:0]            wdog_d;
  logic [ADDR_W-1:0]          next_addr_d;

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_PE-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Only first done per lane per line counts; a num_lines of zero selects the maximum run length.
  always_comb begin
    new_done_d  = bus.pe_done & ~done_mask_q;
    mask_d      = done_mask_q | new_done_d;
    count_d     = sat_add(count_q, popcount(new_done_d & bus.pe_class));
    line_full_d = &mask_d;
    eff_lines_d = (bus.num_lines == '0) ? {1'b0, {LINE_W{1'b1}}} : {1'b0, bus.num_lines};
    last_line_d = (({1'b0, line_idx_q}) + {{LINE_W{1'b0}}, 1'b1}) == eff_lines_d;
    early_hit_d = bus.early_stop_en && (count_d >= bus.threshold);
    wdog_d      = wdog_q + WD_W'(1);
    next_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(line_idx_q + LINE_W'(1));
  end

  // Controller FSM with all outputs registered; abort overrides every other event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      line_idx_q    <= '0;
      count_q       <= '0;
      done_mask_q   <= '0;
      wdog_q        <= '0;
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      sample_q      <= '0;
      classify_en_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      class_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      rd_en_q       <= 1'b0;
      classify_en_q <= 1'b0;
      if (bus.abort) begin
        state_q     <= S_IDLE;
        line_idx_q  <= '0;
        count_q     <= '0;
        done_mask_q <= '0;
        wdog_q      <= '0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        class_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              state_q     <= S_FETCH;
              line_idx_q  <= '0;
              count_q     <= '0;
              done_mask_q <= '0;
              wdog_q      <= '0;
              rd_en_q     <= 1'b1;
              addr_q      <= ADDR_W'(BASE_ADDR);
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              class_q     <= 1'b0;
              timeout_q   <= 1'b0;
            end
          end
          S_FETCH: begin
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            state_q       <= S_CLASSIFY;
            sample_q      <= bus.buf_rdata;
            classify_en_q <= 1'b1;
            wdog_q        <= '0;
          end
          S_CLASSIFY: begin
            count_q <= count_d;
            // A line completing in the watchdog's last cycle is treated as a normal completion.
            if (line_full_d) begin
              done_mask_q <= '0;
              line_idx_q  <= line_idx_q + LINE_W'(1);
              if (last_line_d || early_hit_d) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                class_q <= (count_d >= bus.threshold);
              end else begin
                state_q <= S_FETCH;
                rd_en_q <= 1'b1;
                addr_q  <= next_addr_d;
              end
            end else if (wdog_d == WD_W'(TIMEOUT)) begin
              state_q     <= S_DONE;
              done_mask_q <= mask_d;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              class_q     <= (count_d >= bus.threshold);
              timeout_q   <= 1'b1;
            end else begin
              done_mask_q <= mask_d;
              wdog_q      <= wdog_d;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.buf_rd_en          = rd_en_q;
  assign bus.buf_addr           = addr_q;
  assign bus.pe_sample_data     = sample_q;
  assign bus.pe_classify_en     = classify_en_q;
  assign bus.stress_count       = count_q;
  assign bus.busy               = busy_q;
  assign bus.knn_done           = done_q;
  assign bus.knn_classification = class_q;
  assign bus.timeout_err        = timeout_q;

endmodule
